// File: rtl/fetch_issue_unit_pkg.sv
// Definitions shared by the fetch/issue stage and the Orchestrator:
// bubble and invalid encodings, base opcodes and fetch FSM states.
package fetch_issue_unit_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] INVALID_INST = 32'hFFFF_FFFF;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_issue_unit_inst_window.sv
// Two-deep issued-instruction window: shifts in an issued word or a NOP
// bubble every cycle, and holds still while frozen.
module fetch_issue_unit_inst_window
    import fetch_issue_unit_pkg::*;
#(
    parameter int                    INST_WIDTH_IN_BIT = 32,
    parameter int                    ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_i,
    input  logic                         freeze_i,
    input  logic [INST_WIDTH_IN_BIT-1:0] issue_inst_i,
    input  logic [ADDR_WIDTH-1:0]        issue_pc_i,
    output logic [INST_WIDTH_IN_BIT-1:0] curr_inst_o,
    output logic [INST_WIDTH_IN_BIT-1:0] prev_inst_o,
    output logic [ADDR_WIDTH-1:0]        if_id_pc_o,
    output logic                         if_id_valid_o
);

    localparam logic [INST_WIDTH_IN_BIT-1:0] NOP = INST_WIDTH_IN_BIT'(NOP_INST);

    logic [INST_WIDTH_IN_BIT-1:0] curr_q, prev_q;
    logic [ADDR_WIDTH-1:0]        pc_q;
    logic                         valid_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others (prev_q gets the old curr_q).
    always_ff @(posedge clk) begin
        if (reset) begin
            curr_q  <= NOP;
            prev_q  <= NOP;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else if (freeze_i) begin
            valid_q <= 1'b0;
        end else begin
            prev_q  <= curr_q;
            valid_q <= issue_i;
            if (issue_i) begin
                curr_q <= issue_inst_i;
                pc_q   <= issue_pc_i;
            end else begin
                curr_q <= NOP;
            end
        end
    end

    assign curr_inst_o   = curr_q;
    assign prev_inst_o   = prev_q;
    assign if_id_pc_o    = pc_q;
    assign if_id_valid_o = valid_q;

endmodule

// File: rtl/fetch_issue_unit.sv
// Fetch/issue stage: single-outstanding imem fetch, one-entry issue buffer,
// redirect handling with in-flight response drop, and terminal halt.
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
#(
    parameter int                    INST_WIDTH_IN_BIT = 32,
    parameter int                    ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall_id_if_pl,
    input  logic                         stall_pc_increment,
    input  logic                         halt,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         imem_req,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic                         imem_valid,
    input  logic [INST_WIDTH_IN_BIT-1:0] imem_rdata,
    output logic [INST_WIDTH_IN_BIT-1:0] next_inst,
    output logic [INST_WIDTH_IN_BIT-1:0] curr_inst,
    output logic [INST_WIDTH_IN_BIT-1:0] prev_inst,
    output logic [ADDR_WIDTH-1:0]        if_id_pc,
    output logic                         if_id_valid
);

    localparam logic [INST_WIDTH_IN_BIT-1:0] NOP = INST_WIDTH_IN_BIT'(NOP_INST);

    fetch_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]        pend_q, pend_d;
    logic [INST_WIDTH_IN_BIT-1:0] buf_q, buf_d;
    logic                         drop_q, drop_d;
    logic                         issue;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        drop_d  = drop_q;
        issue   = 1'b0;
        if (halt) begin
            state_d = ST_HALT;
            buf_d   = NOP;
            drop_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    if (redirect_valid) pc_d = redirect_pc;
                end
                ST_WAIT: begin
                    // A redirect before completion can't retarget the live
                    // request, so it parks in pend_q until the response drains.
                    if (redirect_valid) begin
                        if (imem_valid) begin
                            pc_d   = redirect_pc;
                            drop_d = 1'b0;
                        end else begin
                            pend_d = redirect_pc;
                            drop_d = 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (drop_q) begin
                            pc_d   = pend_q;
                            drop_d = 1'b0;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        buf_d   = NOP;
                        state_d = ST_WAIT;
                    end else if (!stall_id_if_pl) begin
                        issue   = 1'b1;
                        buf_d   = NOP;
                        state_d = ST_WAIT;
                        if (!stall_pc_increment) pc_d = pc_q + ADDR_WIDTH'(4);
                    end
                end
                ST_HALT: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            buf_q   <= NOP;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_req  = (state_q == ST_WAIT);
    assign imem_addr = pc_q;
    assign next_inst = buf_q;

    fetch_issue_unit_inst_window #(
        .INST_WIDTH_IN_BIT (INST_WIDTH_IN_BIT),
        .ADDR_WIDTH        (ADDR_WIDTH),
        .RESET_PC          (RESET_PC)
    ) u_inst_window (
        .clk           (clk),
        .reset         (reset),
        .issue_i       (issue),
        .freeze_i      (state_q == ST_HALT),
        .issue_inst_i  (buf_q),
        .issue_pc_i    (pc_q),
        .curr_inst_o   (curr_inst),
        .prev_inst_o   (prev_inst),
        .if_id_pc_o    (if_id_pc),
        .if_id_valid_o (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: directed scenarios plus a randomized run, all
// checked against a program-order model of the issued instruction stream.
module tb_fetch_issue_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_id_if_pl, stall_pc_increment, halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] next_inst, curr_inst, prev_inst, if_id_pc;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    // Reference state: PC of the next instruction in program order, memory
    // latency bookkeeping, and whether a halt has been taken.
    logic [31:0] exp_pc;
    logic        halted;
    int          req_cnt, lat_cur, fixed_lat, n_issue;
    logic        junk_valid;

    fetch_issue_unit #(
        .INST_WIDTH_IN_BIT (32),
        .ADDR_WIDTH        (32),
        .RESET_PC          (32'h0)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_id_if_pl     (stall_id_if_pl),
        .stall_pc_increment (stall_pc_increment),
        .halt               (halt),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_valid         (imem_valid),
        .imem_rdata         (imem_rdata),
        .next_inst          (next_inst),
        .curr_inst          (curr_inst),
        .prev_inst          (prev_inst),
        .if_id_pc           (if_id_pc),
        .if_id_valid        (if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0000_2083;
        return {a[31:2] ^ 30'h123_4567, 2'b01};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset              = 1'b1;
        stall_id_if_pl     = 1'b0;
        stall_pc_increment = 1'b0;
        halt               = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        imem_valid         = 1'b0;
        imem_rdata         = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        exp_pc  = 32'h0;
        halted  = 1'b0;
        req_cnt = 0;
        lat_cur = (fixed_lat != 0) ? fixed_lat : 1;
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_next",  next_inst, NOP);
        check("rst_curr",  curr_inst, NOP);
        check("rst_prev",  prev_inst, NOP);
        check("rst_pc",    if_id_pc, 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
    endtask

    // One clock: drive inputs and the memory response at negedge, then check
    // the post-edge outputs against the program-order model.
    task automatic cycle(input logic st, input logic spi, input logic rv,
                         input logic [31:0] rpc, input logic hl);
        logic [31:0] o_curr, o_prev, o_pc, o_addr;
        logic        o_req, done, was_halted;
        @(negedge clk);
        reset              = 1'b0;
        stall_id_if_pl     = st;
        stall_pc_increment = spi;
        redirect_valid     = rv;
        redirect_pc        = rpc;
        halt               = hl;
        if (imem_req) begin
            req_cnt++;
            imem_valid = (req_cnt >= lat_cur);
            imem_rdata = imem_valid ? mem_word(imem_addr) : $urandom;
        end else begin
            imem_valid = junk_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = $urandom;
        end
        o_curr     = curr_inst;
        o_prev     = prev_inst;
        o_pc       = if_id_pc;
        o_req      = imem_req;
        o_addr     = imem_addr;
        done       = imem_req && imem_valid;
        was_halted = halted;
        @(posedge clk);
        #1;
        if (done) begin
            req_cnt = 0;
            lat_cur = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        end
        if (was_halted) begin
            check("halt_req",   32'(imem_req), 32'd0);
            check("halt_next",  next_inst, NOP);
            check("halt_valid", 32'(if_id_valid), 32'd0);
            check("halt_curr",  curr_inst, o_curr);
            check("halt_prev",  prev_inst, o_prev);
            check("halt_pc",    if_id_pc, o_pc);
        end else begin
            if (st || rv || hl) check("blocked_issue", 32'(if_id_valid), 32'd0);
            if (if_id_valid) begin
                check("issue_pc",   if_id_pc, exp_pc);
                check("issue_inst", curr_inst, mem_word(exp_pc));
                exp_pc = spi ? exp_pc : exp_pc + 32'd4;
                n_issue++;
            end else begin
                check("bubble_inst", curr_inst, NOP);
            end
            check("prev_shift", prev_inst, o_curr);
            if (rv && !hl) exp_pc = rpc;
            if (hl) halted = 1'b1;
            if (next_inst !== NOP) check("next_inst", next_inst, mem_word(exp_pc));
            if (o_req && !done && imem_req) check("addr_stable", imem_addr, o_addr);
        end
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        stall_id_if_pl = 1'b0; stall_pc_increment = 1'b0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_valid = 1'b0; imem_rdata = 32'h0;
        fixed_lat = 1; junk_valid = 1'b0; n_issue = 0;

        do_reset();

        // Streaming with 1-cycle memory: fetch 0,4,8 and alternate valid
        cycle(0, 0, 0, 32'h0, 0);
        check("idle_to_wait_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        cycle(0, 0, 0, 32'h0, 0);
        check("hold_next", next_inst, mem_word(32'h0));
        check("hold_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 32'h0, 0);
            check("alt_valid", 32'(if_id_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) check("fetch_addr", imem_addr, 32'(4 * (k / 2 + 1)));
        end

        // Buffered load held through a two-cycle stall
        cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 1, 32'h10, 0);
        check("redir_first_addr", imem_addr, 32'h10);
        check("redir_first_req", 32'(imem_req), 32'd1);
        cycle(0, 0, 0, 32'h0, 0);
        check("load_buffered", next_inst, 32'h0000_2083);
        for (int k = 0; k < 2; k++) begin
            cycle(1, 0, 0, 32'h0, 0);
            check("stall_next_held", next_inst, 32'h0000_2083);
            check("stall_bubble", curr_inst, NOP);
        end
        cycle(0, 0, 0, 32'h0, 0);
        check("load_issued", curr_inst, 32'h0000_2083);
        check("load_pc", if_id_pc, 32'h10);

        // Redirect while a 3-cycle fetch of 0x8 is outstanding
        cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 1, 32'h8, 0);
        lat_cur = 3;
        cycle(0, 0, 1, 32'h100, 0);
        check("outstanding_addr", imem_addr, 32'h8);
        cycle(0, 0, 0, 32'h0, 0);
        check("outstanding_addr2", imem_addr, 32'h8);
        fixed_lat = 1;
        cycle(0, 0, 0, 32'h0, 0);
        check("pending_addr", imem_addr, 32'h100);
        check("pending_req", 32'(imem_req), 32'd1);
        cycle(0, 0, 0, 32'h0, 0);
        check("pending_next", next_inst, mem_word(32'h100));
        cycle(0, 0, 0, 32'h0, 0);
        check("pending_issue_pc", if_id_pc, 32'h100);

        // Redirect in the same cycle as an issue from HOLD
        cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 1, 32'h200, 0);
        check("redir_wins_valid", 32'(if_id_valid), 32'd0);
        check("redir_wins_curr", curr_inst, NOP);
        check("redir_wins_addr", imem_addr, 32'h200);
        check("redir_wins_req", 32'(imem_req), 32'd1);

        // PC wrap-around
        cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0);
        check("wrap_issue_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr, 32'h0);

        // Randomized traffic
        fixed_lat  = 0;
        junk_valid = 1'b1;
        n_issue    = 0;
        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 19) == 0, $urandom & ~32'h3, 0);
        end
        check("random_progress", 32'(n_issue >= 100), 32'd1);

        // Halt during WAIT; later responses and redirects are ignored
        junk_valid = 1'b0;
        guard = 0;
        while (!imem_req && guard < 50) begin
            cycle(0, 0, 0, 32'h0, 0);
            guard++;
        end
        check("reach_wait", 32'(imem_req), 32'd1);
        lat_cur = 1000;
        cycle(0, 0, 0, 32'h0, 1);
        check("halt_req_drop", 32'(imem_req), 32'd0);
        check("halt_entry_valid", 32'(if_id_valid), 32'd0);
        junk_valid = 1'b1;
        for (int k = 0; k < 6; k++) cycle(0, 0, 1, $urandom & ~32'h3, 0);
        junk_valid = 1'b0;

        // Reset out of halt, then reset mid-request
        fixed_lat = 1;
        do_reset();
        cycle(0, 0, 0, 32'h0, 0);
        lat_cur = 1000;
        cycle(0, 0, 0, 32'h0, 0);
        check("midreq_req", 32'(imem_req), 32'd1);
        do_reset();
        cycle(0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0);
        check("post_reset_fetch", next_inst, mem_word(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
